// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: opcodes, funct3 codes,
// FSM encoding and width defaults.
package mem_lsu_pkg;

    localparam int XLEN_DEF = 64;
    localparam int AW_DEF   = 64;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } lsu_state_e;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [2:0] off);
        case (f3[1:0])
            2'b01:   return off[0];
            2'b10:   return |off[1:0];
            2'b11:   return |off;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane steering: store data/strobe shift and load extract/extend.
// Bytes shifted beyond lane 7 fall off the top of the bus.
module mem_lsu_align
    import mem_lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int STRB_W = XLEN / 8
) (
    input  logic [2:0]        off_i,
    input  logic [2:0]        funct3_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   rdata_i,
    output logic [XLEN-1:0]   wdata_o,
    output logic [STRB_W-1:0] wstrb_o,
    output logic [XLEN-1:0]   load_data_o
);

    logic [STRB_W-1:0] base_strb;
    logic [XLEN-1:0]   lane;

    always_comb begin
        base_strb = '0;
        case (funct3_i[1:0])
            2'b00:   base_strb = STRB_W'(8'h01);
            2'b01:   base_strb = STRB_W'(8'h03);
            2'b10:   base_strb = STRB_W'(8'h0F);
            default: base_strb = STRB_W'(8'hFF);
        endcase
        wstrb_o = base_strb << off_i;
        wdata_o = store_data_i << {off_i, 3'b000};

        lane = rdata_i >> {off_i, 3'b000};
        load_data_o = '0;
        case (funct3_i)
            F3_B:    load_data_o = {{(XLEN-8){lane[7]}}, lane[7:0]};
            F3_H:    load_data_o = {{(XLEN-16){lane[15]}}, lane[15:0]};
            F3_W:    load_data_o = {{(XLEN-32){lane[31]}}, lane[31:0]};
            F3_D:    load_data_o = lane;
            F3_BU:   load_data_o = {{(XLEN-8){1'b0}}, lane[7:0]};
            F3_HU:   load_data_o = {{(XLEN-16){1'b0}}, lane[15:0]};
            F3_WU:   load_data_o = {{(XLEN-32){1'b0}}, lane[31:0]};
            default: load_data_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage LSU: req/gnt/rvalid bus transaction for loads/stores, one-cycle wb pulse per op.
// Optional misaligned-access trap enabled by defining MEM_LSU_MISALIGN_TRAP_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int AW     = AW_DEF,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [4:0]        rd_addr_i,
    input  logic              wreg_i,
    output logic              stall_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [AW-1:0]     dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    output logic [STRB_W-1:0] dmem_wstrb_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_addr_o,
    output logic              wb_wreg_o,
    output logic [XLEN-1:0]   wb_wdata_o,
    output logic [4:0]        mem_back_rd_addr_o,
    output logic              mem_back_wreg_o,
    output logic [XLEN-1:0]   mem_back_wdata_o,
    output logic              misalign_o
);

    lsu_state_e state_q, state_d;

    logic [2:0]      cap_f3_q;
    logic [AW-1:0]   cap_addr_q;
    logic [XLEN-1:0] cap_sdata_q;
    logic [4:0]      cap_rd_q;
    logic            cap_wreg_q;
    logic            cap_store_q;

    logic            wb_valid_q, wb_valid_d;
    logic [4:0]      wb_rd_q, wb_rd_d;
    logic            wb_wreg_q, wb_wreg_d;
    logic [XLEN-1:0] wb_wdata_q, wb_wdata_d;
    logic            misalign_q, misalign_d;

    logic            accept, is_mem, mis_now;
    logic [XLEN-1:0] al_wdata, al_load;
    logic [STRB_W-1:0] al_wstrb;

    assign stall_o = (state_q != ST_IDLE);
    assign accept  = in_valid_i && !stall_o;
    assign is_mem  = (opcode_i == OPC_LOAD) || (opcode_i == OPC_STORE);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
    assign mis_now = is_misaligned(funct3_i, addr_i[2:0]);
`else
    assign mis_now = 1'b0;
`endif

    mem_lsu_align #(.XLEN(XLEN), .STRB_W(STRB_W)) u_align (
        .off_i        (cap_addr_q[2:0]),
        .funct3_i     (cap_f3_q),
        .store_data_i (cap_sdata_q),
        .rdata_i      (dmem_rdata_i),
        .wdata_o      (al_wdata),
        .wstrb_o      (al_wstrb),
        .load_data_o  (al_load)
    );

    always_comb begin
        state_d      = state_q;
        wb_valid_d   = 1'b0;
        wb_wreg_d    = 1'b0;
        misalign_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_wdata_d   = wb_wdata_q;
        dmem_req_o   = 1'b0;
        dmem_we_o    = 1'b0;
        dmem_addr_o  = '0;
        dmem_wdata_o = '0;
        dmem_wstrb_o = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept && !is_mem) begin
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_addr_i;
                    wb_wreg_d  = wreg_i;
                    wb_wdata_d = XLEN'(addr_i);
                end else if (accept && mis_now) begin
                    // Trapped access completes locally without touching the bus.
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_addr_i;
                    wb_wdata_d = '0;
                    misalign_d = 1'b1;
                end else if (accept) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                dmem_req_o   = 1'b1;
                dmem_we_o    = cap_store_q;
                dmem_addr_o  = {cap_addr_q[AW-1:3], 3'b000};
                dmem_wdata_o = al_wdata;
                dmem_wstrb_o = al_wstrb;
                if (dmem_gnt_i) state_d = ST_RESP;
            end
            ST_RESP: begin
                if (dmem_rvalid_i) begin
                    state_d    = ST_IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = cap_rd_q;
                    wb_wreg_d  = cap_wreg_q && !cap_store_q;
                    wb_wdata_d = cap_store_q ? '0 : al_load;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cap_f3_q    <= '0;
            cap_addr_q  <= '0;
            cap_sdata_q <= '0;
            cap_rd_q    <= '0;
            cap_wreg_q  <= 1'b0;
            cap_store_q <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_wreg_q  <= wb_wreg_d;
            wb_wdata_q <= wb_wdata_d;
            misalign_q <= misalign_d;
            if (accept && is_mem) begin
                cap_f3_q    <= funct3_i;
                cap_addr_q  <= addr_i;
                cap_sdata_q <= store_data_i;
                cap_rd_q    <= rd_addr_i;
                cap_wreg_q  <= wreg_i;
                cap_store_q <= (opcode_i == OPC_STORE);
            end
        end
    end

    assign wb_valid_o         = wb_valid_q;
    assign wb_rd_addr_o       = wb_rd_q;
    assign wb_wreg_o          = wb_wreg_q;
    assign wb_wdata_o         = wb_wdata_q;
    assign mem_back_rd_addr_o = wb_rd_q;
    assign mem_back_wreg_o    = wb_wreg_q;
    assign mem_back_wdata_o   = wb_wdata_q;
    assign misalign_o         = misalign_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed vector table, hand-written corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_mem_lsu;

    localparam logic [6:0] LOAD  = 7'b0000011;
    localparam logic [6:0] STORE = 7'b0100011;
    localparam logic [6:0] ALU   = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid_i;
    logic [6:0]  opcode_i;
    logic [2:0]  funct3_i;
    logic [63:0] addr_i, store_data_i;
    logic [4:0]  rd_addr_i;
    logic        wreg_i;
    logic        stall_o, dmem_req_o, dmem_we_o;
    logic [63:0] dmem_addr_o, dmem_wdata_o;
    logic [7:0]  dmem_wstrb_o;
    logic        dmem_gnt_i, dmem_rvalid_i;
    logic [63:0] dmem_rdata_i;
    logic        wb_valid_o, wb_wreg_o, mem_back_wreg_o, misalign_o;
    logic [4:0]  wb_rd_addr_o, mem_back_rd_addr_o;
    logic [63:0] wb_wdata_o, mem_back_wdata_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    mem_lsu dut (
        .clk(clk), .rst(rst), .in_valid_i(in_valid_i), .opcode_i(opcode_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .store_data_i(store_data_i),
        .rd_addr_i(rd_addr_i), .wreg_i(wreg_i), .stall_o(stall_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
        .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i),
        .dmem_rdata_i(dmem_rdata_i), .wb_valid_o(wb_valid_o),
        .wb_rd_addr_o(wb_rd_addr_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
        .mem_back_rd_addr_o(mem_back_rd_addr_o), .mem_back_wreg_o(mem_back_wreg_o),
        .mem_back_wdata_o(mem_back_wdata_o), .misalign_o(misalign_o)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    // Reference model: plain arithmetic on access size and byte offset.
    function automatic logic [63:0] m_strb(input logic [2:0] f3, input logic [63:0] a);
        int n = 1 << f3[1:0];
        longint unsigned m = ((64'd1 << n) - 1) << (a % 8);
        return m & 64'hFF;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [63:0] a);
        return sd << (8 * (a % 8));
    endfunction

    function automatic logic [63:0] m_load(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] rdata);
        int n = 1 << f3[1:0];
        logic [63:0] b, mask, v;
        if (f3 == 3'b111) return 64'd0;
        b = rdata >> (8 * (a % 8));
        if (n == 8) return b;
        mask = (64'd1 << (8 * n)) - 1;
        v = b & mask;
        if (!f3[2] && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        return v;
    endfunction

    task automatic do_op(input string nm, input logic [6:0] opc, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] sd, input logic [63:0] rdata,
                         input logic [4:0] rd, input logic wr, input int gd, input int rvd,
                         input logic [63:0] e_data, input logic e_wreg,
                         input logic [7:0] e_strb, input logic [63:0] e_bus);
        logic is_mem = (opc == LOAD) || (opc == STORE);
        @(negedge clk);
        in_valid_i = 1'b1; opcode_i = opc; funct3_i = f3; addr_i = a;
        store_data_i = sd; rd_addr_i = rd; wreg_i = wr;
        @(negedge clk);
        in_valid_i = 1'b0;
        if (is_mem) begin
            for (int i = 0; i <= gd; i++) begin
                chk({nm, " req"}, dmem_req_o, 1'b1);
                chk({nm, " addr"}, dmem_addr_o, a & ~64'd7);
                if (i == 0) begin
                    chk({nm, " we"}, dmem_we_o, opc == STORE);
                    chk({nm, " stall"}, stall_o, 1'b1);
                    if (opc == STORE) begin
                        chk({nm, " wstrb"}, dmem_wstrb_o, e_strb);
                        chk({nm, " wdata_bus"}, dmem_wdata_o, e_bus);
                    end
                end
                if (i == gd) dmem_gnt_i = 1'b1;
                @(negedge clk);
                dmem_gnt_i = 1'b0;
            end
            for (int i = 0; i <= rvd; i++) begin
                chk({nm, " req_resp"}, dmem_req_o, 1'b0);
                if (i == rvd) begin dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata; end
                @(negedge clk);
                dmem_rvalid_i = 1'b0;
            end
        end else begin
            chk({nm, " stall_alu"}, stall_o, 1'b0);
        end
        chk({nm, " wb_valid"}, wb_valid_o, 1'b1);
        chk({nm, " wb_wreg"}, wb_wreg_o, e_wreg);
        chk({nm, " fwd_wreg"}, mem_back_wreg_o, e_wreg);
        chk({nm, " wb_rd"}, mem_back_rd_addr_o, rd);
        if (opc != STORE) begin
            chk({nm, " wb_data"}, wb_wdata_o, e_data);
            chk({nm, " fwd_data"}, mem_back_wdata_o, e_data);
        end
        chk({nm, " misalign"}, misalign_o, 1'b0);
        @(negedge clk);
        chk({nm, " wb_pulse"}, wb_valid_o, 1'b0);
        chk({nm, " fwd_wreg_idle"}, mem_back_wreg_o, 1'b0);
    endtask

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] addr, sdata, rdata;
        logic [4:0]  rd;
        logic        wreg;
        logic [63:0] e_data;
        logic        e_wreg;
        logic [7:0]  e_strb;
        logic [63:0] e_bus;
    } vec_t;

    vec_t vt[$];

    initial begin
        logic [6:0]  r_opc;
        logic [2:0]  r_f3;
        logic [63:0] r_a, r_sd, r_rd;
        logic [4:0]  r_dst;
        logic        r_w;
        int          kind;

        vt.push_back('{STORE, 3'b011, 64'h1000, 64'h1122334455667788, 64'h0, 5'd3, 1'b1,
                       64'h0, 1'b0, 8'hFF, 64'h1122334455667788});
        vt.push_back('{LOAD, 3'b000, 64'h2005, 64'h0, 64'h000080AA00000000, 5'd9, 1'b1,
                       64'hFFFFFFFFFFFFFF80, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b100, 64'h2005, 64'h0, 64'h000080AA00000000, 5'd9, 1'b1,
                       64'h80, 1'b1, 8'h0, 64'h0});
        vt.push_back('{ALU, 3'b000, 64'h42, 64'h0, 64'h0, 5'd7, 1'b1,
                       64'h42, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b001, 64'h100006, 64'h0, 64'h8001000000000000, 5'd10, 1'b1,
                       64'hFFFFFFFFFFFF8001, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b101, 64'h100006, 64'h0, 64'h8001000000000000, 5'd10, 1'b1,
                       64'h8001, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b010, 64'h4, 64'h0, 64'h89ABCDEF00000000, 5'd11, 1'b1,
                       64'hFFFFFFFF89ABCDEF, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b110, 64'h4, 64'h0, 64'h89ABCDEF00000000, 5'd11, 1'b1,
                       64'h89ABCDEF, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b011, 64'h8, 64'h0, 64'hDEADBEEFCAFEF00D, 5'd12, 1'b1,
                       64'hDEADBEEFCAFEF00D, 1'b1, 8'h0, 64'h0});
        vt.push_back('{LOAD, 3'b111, 64'h8, 64'h0, 64'hDEADBEEFCAFEF00D, 5'd13, 1'b1,
                       64'h0, 1'b1, 8'h0, 64'h0});
        vt.push_back('{STORE, 3'b000, 64'h1003, 64'h00000000000000AB, 64'h0, 5'd1, 1'b1,
                       64'h0, 1'b0, 8'h08, 64'h00000000AB000000});
        vt.push_back('{STORE, 3'b010, 64'h2004, 64'h1122334455667788, 64'h0, 5'd2, 1'b0,
                       64'h0, 1'b0, 8'hF0, 64'h5566778800000000});
        vt.push_back('{LOAD, 3'b011, 64'h18, 64'h0, 64'h0123456789ABCDEF, 5'd14, 1'b0,
                       64'h0123456789ABCDEF, 1'b0, 8'h0, 64'h0});

        rst = 1'b0; in_valid_i = 1'b0; opcode_i = '0; funct3_i = '0; addr_i = '0;
        store_data_i = '0; rd_addr_i = '0; wreg_i = 1'b0;
        dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;

        repeat (2) @(negedge clk);
        chk("rst stall", stall_o, 1'b0);
        chk("rst req", dmem_req_o, 1'b0);
        chk("rst wb_valid", wb_valid_o, 1'b0);
        chk("rst wb_data", wb_wdata_o, 64'h0);
        chk("rst misalign", misalign_o, 1'b0);
        rst = 1'b1;

        for (int i = 0; i < vt.size(); i++)
            do_op($sformatf("vec%0d", i), vt[i].opc, vt[i].f3, vt[i].addr, vt[i].sdata,
                  vt[i].rdata, vt[i].rd, vt[i].wreg, i % 3, (i + 1) % 2,
                  vt[i].e_data, vt[i].e_wreg, vt[i].e_strb, vt[i].e_bus);

        // Grant ignored in IDLE.
        @(negedge clk); dmem_gnt_i = 1'b1;
        @(negedge clk); dmem_gnt_i = 1'b0;
        chk("idle_gnt req", dmem_req_o, 1'b0);
        chk("idle_gnt stall", stall_o, 1'b0);

        // Grant held off 3 cycles; second bundle waits; rvalid in REQ ignored.
        @(negedge clk);
        in_valid_i = 1'b1; opcode_i = LOAD; funct3_i = 3'b011; addr_i = 64'h50; rd_addr_i = 5'd4; wreg_i = 1'b1;
        @(negedge clk);
        opcode_i = ALU; addr_i = 64'h42; rd_addr_i = 5'd7;
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hBAD;
        for (int i = 0; i <= 3; i++) begin
            chk("hold req", dmem_req_o, 1'b1);
            chk("hold addr", dmem_addr_o, 64'h50);
            chk("hold stall", stall_o, 1'b1);
            chk("hold wb_valid", wb_valid_o, 1'b0);
            if (i == 3) dmem_gnt_i = 1'b1;
            @(negedge clk);
            dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
        end
        chk("hold resp req", dmem_req_o, 1'b0);
        chk("hold resp wb", wb_valid_o, 1'b0);
        dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'h1234;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk("hold ld wb_valid", wb_valid_o, 1'b1);
        chk("hold ld data", wb_wdata_o, 64'h1234);
        chk("hold ld rd", wb_rd_addr_o, 5'd4);
        chk("hold ld stall", stall_o, 1'b0);
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("held alu wb_valid", wb_valid_o, 1'b1);
        chk("held alu data", wb_wdata_o, 64'h42);
        chk("held alu rd", wb_rd_addr_o, 5'd7);
        @(negedge clk);
        chk("held alu pulse", wb_valid_o, 1'b0);

        // Reset while in RESP; late response must be dropped.
        in_valid_i = 1'b1; opcode_i = LOAD; funct3_i = 3'b011; addr_i = 64'h60; rd_addr_i = 5'd5;
        @(negedge clk);
        in_valid_i = 1'b0; dmem_gnt_i = 1'b1;
        @(negedge clk);
        dmem_gnt_i = 1'b0;
        chk("rstmid stall_pre", stall_o, 1'b1);
        rst = 1'b0;
        #1;
        chk("rstmid stall", stall_o, 1'b0);
        chk("rstmid req", dmem_req_o, 1'b0);
        chk("rstmid wb_valid", wb_valid_o, 1'b0);
        @(negedge clk);
        rst = 1'b1; dmem_rvalid_i = 1'b1; dmem_rdata_i = 64'hFFFF;
        @(negedge clk);
        dmem_rvalid_i = 1'b0;
        chk("rstmid late wb", wb_valid_o, 1'b0);
        chk("rstmid late stall", stall_o, 1'b0);
        do_op("after_rst", ALU, 3'b000, 64'h99, 64'h0, 64'h0, 5'd8, 1'b1, 0, 0,
              64'h99, 1'b1, 8'h0, 64'h0);

`ifdef MEM_LSU_MISALIGN_TRAP_EN
        @(negedge clk);
        in_valid_i = 1'b1; opcode_i = LOAD; funct3_i = 3'b010; addr_i = 64'h3002; rd_addr_i = 5'd6; wreg_i = 1'b1;
        @(negedge clk);
        in_valid_i = 1'b0;
        chk("mis req", dmem_req_o, 1'b0);
        chk("mis flag", misalign_o, 1'b1);
        chk("mis wb_valid", wb_valid_o, 1'b1);
        chk("mis wreg", wb_wreg_o, 1'b0);
        chk("mis stall", stall_o, 1'b0);
        @(negedge clk);
        chk("mis flag pulse", misalign_o, 1'b0);
        chk("mis wb pulse", wb_valid_o, 1'b0);
`else
        do_op("mis_lw", LOAD, 3'b010, 64'h3002, 64'h0, 64'hAABBCCDDEEFF1122, 5'd6, 1'b1, 0, 0,
              64'hFFFFFFFFCCDDEEFF, 1'b1, 8'h0, 64'h0);
        do_op("mis_sd", STORE, 3'b011, 64'h1003, 64'h1122334455667788, 64'h0, 5'd6, 1'b1, 1, 0,
              64'h0, 1'b0, 8'hF8, 64'h4455667788000000);
`endif

        for (int i = 0; i < 40; i++) begin
            kind  = $urandom_range(0, 2);
            r_opc = (kind == 0) ? LOAD : (kind == 1) ? STORE : ALU;
            r_f3  = (kind == 1) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
            r_a   = {$urandom, $urandom};
`ifdef MEM_LSU_MISALIGN_TRAP_EN
            if (kind != 2) r_a = r_a & ~((64'd1 << r_f3[1:0]) - 1);
`endif
            r_sd  = {$urandom, $urandom};
            r_rd  = {$urandom, $urandom};
            r_dst = 5'($urandom);
            r_w   = 1'($urandom);
            do_op($sformatf("rnd%0d", i), r_opc, r_f3, r_a, r_sd, r_rd, r_dst, r_w,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  (kind == 2) ? r_a : m_load(r_f3, r_a, r_rd),
                  (kind == 1) ? 1'b0 : r_w,
                  8'(m_strb(r_f3, r_a)), m_wdata(r_sd, r_a));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mem_lsu.md
Name: mem_lsu

Overview:
Memory-stage load/store unit that consumes the execute stage's result bundle.
- Inputs per op: ALU result/effective address, store data, opcode, funct3, rd, wreg.
- Performs a request/grant/response transaction on the data-memory bus for loads and stores.
- Aligns and extends load data, and produces the mem_back_* forwarding bundle and the write-back result.
- Stalls upstream while a memory transaction is in flight.

Parameters:
XLEN, 64, register/data width.
AW, 64, address width.
STRB_W, XLEN/8, byte-strobe width of the data bus.

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
in_valid_i  in  1  execute bundle valid
opcode_i  in  7  opcode from execute
funct3_i  in  3  size/sign selector
addr_i  in  AW  effective address (loads/stores) or ALU result (other ops)
store_data_i  in  XLEN  rs2 data for stores
rd_addr_i  in  5  destination register
wreg_i  in  1  destination write enable
stall_o  out  1  upstream must hold the bundle
dmem_req_o  out  1  bus request
dmem_we_o  out  1  1 = store
dmem_addr_o  out  AW  doubleword-aligned address {addr[AW-1:3],3'b0}
dmem_wdata_o  out  XLEN  store data shifted by 8*addr[2:0]
dmem_wstrb_o  out  STRB_W  byte strobes shifted by addr[2:0]
dmem_gnt_i  in  1  request accepted
dmem_rvalid_i  in  1  response/ack (loads and stores)
dmem_rdata_i  in  XLEN  load data
wb_valid_o  out  1  write-back result valid
wb_rd_addr_o  out  5  write-back rd
wb_wreg_o  out  1  write-back enable, gated by wb_valid_o
wb_wdata_o  out  XLEN  write-back data
mem_back_rd_addr_o  out  5  forwarding rd (= wb_rd_addr_o)
mem_back_wreg_o  out  1  forwarding enable (= wb_wreg_o)
mem_back_wdata_o  out  XLEN  forwarding data (= wb_wdata_o)
misalign_o  out  1  misaligned access flag (optional feature)

Behaviour:
- Reset (rst=0, async): state IDLE; all outputs 0; captured bundle cleared.
- FSM states: IDLE, REQ, RESP.
- Acceptance: bundle accepted when in_valid_i && !stall_o; stall_o = (state != IDLE).
- Non-memory op accepted in IDLE: next cycle wb_valid_o=1, wb_wdata_o=addr_i, wb_wreg_o=wreg_i; state stays IDLE.
- Memory op, opcode 0000011 (load) or 0100011 (store), accepted in IDLE: capture the bundle, then go to REQ.
- REQ: dmem_req_o=1; addr/wdata/wstrb/we are stable until grant; dmem_gnt_i -> RESP.
- RESP: dmem_req_o=0; dmem_rvalid_i -> IDLE, and wb_valid_o=1 the next cycle.
- Minimum memory-op latency: accept T0, req+gnt T1, rvalid T2, wb_valid_o T3.
- wb_valid_o is a 1-cycle pulse per accepted op.
- Store strobe masks by funct3: 000 -> 0x01, 001 -> 0x03, 010 -> 0x0F, 011 -> 0xFF, each << addr[2:0].
- Store write-back: wb_wreg_o=0 regardless of wreg_i.
- Load extract: byte lane = rdata >> 8*addr[2:0].
  - Sign-extend for LB 000, LH 001, LW 010.
  - LD 011 is full width.
  - Zero-extend for LBU 100, LHU 101, LWU 110.
  - funct3 111 -> data 0.
- rvalid in IDLE or REQ: ignored.
- gnt outside REQ: ignored.
- Reset mid-transaction: FSM returns to IDLE immediately, dmem_req_o drops, and the late response is ignored.
- Forwarding outputs are wires from the wb registers; mem_back_wreg_o=0 when wb_valid_o=0.

Optional Feature:
MEM_LSU_MISALIGN_TRAP_EN.
- Defined: an access is misaligned when addr is not a multiple of the access size (H: addr[0]; W: addr[1:0]; D: addr[2:0]). A misaligned access:
  - issues no bus request;
  - completes next cycle with wb_valid_o=1, wb_wreg_o=0, misalign_o=1 for one cycle.
- Undefined: misalign_o tied 0; the access proceeds, and bytes shifted beyond lane 7 are dropped.

Decomposition:
Shared package holds:
- opcode constants (LOAD, STORE);
- funct3 load/store codes;
- the FSM state encoding;
- the XLEN/AW defaults.

One combinational sub-module, mem_lsu_align, holds store shift/strobe generation and load extraction/extension.

Test Plan:
- SD addr 0x1000, data 0x1122334455667788, gnt T1, rvalid T2 -> dmem_addr 0x1000, wstrb 0xFF, we=1; wb_valid T3 with wreg=0.
- LB addr 0x2005, rdata 0x0000_80AA_0000_0000 -> lane 5 = 0x80 -> wb_wdata 0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
- ADD result 0x42, rd=7, wreg=1 -> wb_valid and mem_back_wreg next cycle with data 0x42, rd 7; stall_o never asserted.
- Grant held off 3 cycles -> dmem_req_o high 3+1 cycles with stable addr, stall_o high throughout, and a second in_valid bundle held until IDLE.
- rst asserted in RESP, then rvalid arrives -> outputs 0, no wb_valid; next accepted op completes normally.
- With MEM_LSU_MISALIGN_TRAP_EN, LW addr 0x3002 -> no dmem_req_o; misalign_o=1 and wb_valid=1 with wreg=0 next cycle.
